mux_2to1: RTL and testbench

- Two-input flit multiplexer for the NoC router output stage.
- Selects one of two input flit channels (data, valid, virtual-channel id) using a one-hot port-select vector.
- Drives the selection onto a single output channel through a registered output stage.
- Used for energy characterisation and as the per-output-port crossbar leg inside the router.

---
 rtl/noc_pkg.sv | 25 ++
 rtl/mux_2to1.sv | 80 ++++++++
 tb/tb_mux_2to1.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: channel widths, flit type encodings and port-select constants
// used by the router crossbar legs.
package noc_pkg;

    localparam int DATAW = 66;
    localparam int VCHW  = 2;
    localparam int PORTW = 5;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_HEAD = 2'b01,
        TYPE_DATA = 2'b10,
        TYPE_TAIL = 2'b11
    } flit_type_e;

    localparam logic [PORTW-1:0] SEL_P0 = 5'b00001;
    localparam logic [PORTW-1:0] SEL_P1 = 5'b00010;

    // The two top bits of a flit carry its type; the rest is payload.
    function automatic logic [DATAW-1:0] make_flit(input flit_type_e ftype,
                                                   input logic [DATAW-3:0] payload);
        return {ftype, payload};
    endfunction

endpackage

// File: rtl/mux_2to1.sv
// Two-input flit multiplexer: one-hot select with port 0 priority, driving a single
// output channel through an optional one-cycle register stage.
module mux_2to1
    import noc_pkg::*;
#(
    parameter int DATA_W  = DATAW,
    parameter int VCH_W   = VCHW,
    parameter int PORT_W  = PORTW,
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [PORT_W-1:0] sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
);

    logic [DATA_W-1:0] mux_data;
    logic              mux_valid;
    logic [VCH_W-1:0]  mux_vch;

    // Only the two low select bits name real ports; the rest are router-wide lanes.
    logic unused_sel_hi;
    assign unused_sel_hi = ^sel[PORT_W-1:2];

    // The if/else chain keeps the unselected port (even when X) off the outputs.
    always_comb begin
        mux_data  = '0;
        mux_valid = 1'b0;
        mux_vch   = '0;
        if (sel[0]) begin
            mux_data  = idata_0;
            mux_valid = ivalid_0;
            mux_vch   = ivch_0;
        end else if (sel[1]) begin
            mux_data  = idata_1;
            mux_valid = ivalid_1;
            mux_vch   = ivch_1;
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [DATA_W-1:0] data_q;
            logic              valid_q;
            logic [VCH_W-1:0]  vch_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    vch_q   <= '0;
                end else begin
                    data_q  <= mux_data;
                    valid_q <= mux_valid;
                    vch_q   <= mux_vch;
                end
            end

            assign odata  = data_q;
            assign ovalid = valid_q;
            assign ovch   = vch_q;
        end else begin : g_comb_out
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign odata  = mux_data;
            assign ovalid = mux_valid;
            assign ovch   = mux_vch;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// Randomised scoreboard bench for mux_2to1 (registered output): a driver pushes the
// expected channel for every cycle and a monitor pops and compares one cycle later.
module tb_mux_2to1;
    import noc_pkg::*;

    logic             clk;
    logic             rst;
    logic [DATAW-1:0] idata_0, idata_1, odata;
    logic             ivalid_0, ivalid_1, ovalid;
    logic [VCHW-1:0]  ivch_0, ivch_1, ovch;
    logic [PORTW-1:0] sel;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic             valid;
        logic [VCHW-1:0]  vch;
    } chan_t;

    chan_t expected_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    mux_2to1 #(.DATA_W(DATAW), .VCH_W(VCHW), .PORT_W(PORTW), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
        .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
        .sel(sel),
        .odata(odata), .ovalid(ovalid), .ovch(ovch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATAW-1:0] rand_flit();
        logic [1:0] ftype;
        ftype = 2'($urandom_range(0, 3));
        return {ftype, $urandom, $urandom};
    endfunction

    // Alternating long runs of ones and zeros, rotated a little further each flit.
    function automatic logic [26:0] run_pattern(input int k);
        logic [26:0] base;
        logic [53:0] both;
        int          r;
        base = (k % 2 == 0) ? 27'h7FFF800 : 27'h01FFFFF;
        r    = (k * 4) % 27;
        both = {base, base} >> r;
        return both[26:0];
    endfunction

    task automatic checkOutput(input string name, input logic [DATAW-1:0] actual,
                               input logic [DATAW-1:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // The expected channel follows the selection rules directly: reset wins, then the
    // lowest set select bit among the two real ports, otherwise an all-zero idle channel.
    task automatic applyStimulus(input string tag, input logic r, input logic [PORTW-1:0] s,
                                 input logic [DATAW-1:0] d0, input logic v0, input logic [VCHW-1:0] c0,
                                 input logic [DATAW-1:0] d1, input logic v1, input logic [VCHW-1:0] c1);
        chan_t ports[2];
        chan_t exp_chan;
        int    pick;
        @(negedge clk);
        rst = r; sel = s;
        idata_0 = d0; ivalid_0 = v0; ivch_0 = c0;
        idata_1 = d1; ivalid_1 = v1; ivch_1 = c1;
        ports[0] = '{data: d0, valid: v0, vch: c0};
        ports[1] = '{data: d1, valid: v1, vch: c1};
        pick = -1;
        if (!r) begin
            for (int p = 0; p < 2; p++) begin
                if (pick < 0 && s[p]) pick = p;
            end
        end
        exp_chan = (pick < 0) ? chan_t'(0) : ports[pick];
        expected_q.push_back(exp_chan);
        tag_q.push_back(tag);
    endtask

    // Monitor: every edge the output stage updates, so each edge retires one expectation.
    always @(posedge clk) begin
        #1;
        if (expected_q.size() > 0) begin
            chan_t e;
            string t;
            e = expected_q.pop_front();
            t = tag_q.pop_front();
            checkOutput({t, ".data"}, odata, e.data);
            checkOutput({t, ".valid"}, {{(DATAW-1){1'b0}}, ovalid}, {{(DATAW-1){1'b0}}, e.valid});
            checkOutput({t, ".vch"}, {{(DATAW-VCHW){1'b0}}, ovch}, {{(DATAW-VCHW){1'b0}}, e.vch});
        end
    end

    initial begin
        logic [DATAW-1:0] flit_a, flit_b, flit;
        int               waited;

        rst = 1'b1; sel = '0;
        idata_0 = '0; ivalid_0 = 1'b0; ivch_0 = '0;
        idata_1 = '0; ivalid_1 = 1'b0; ivch_1 = '0;
        repeat (2) @(posedge clk);

        applyStimulus("reset0", 1'b1, SEL_P1, 66'h1_1111_2222_3333_4444, 1'b1, 2'd3,
                      66'h2_5555_6666_7777_8888, 1'b1, 2'd2);
        applyStimulus("reset1", 1'b1, SEL_P1, 66'h1_1111_2222_3333_4444, 1'b1, 2'd3,
                      66'h2_5555_6666_7777_8888, 1'b1, 2'd2);
        applyStimulus("post_reset", 1'b0, SEL_P1, 66'h1_1111_2222_3333_4444, 1'b1, 2'd3,
                      66'h2_5555_6666_7777_8888, 1'b1, 2'd2);

        for (int pkt = 0; pkt < 10; pkt++) begin
            applyStimulus("p1_head", 1'b0, 5'b00010, rand_flit(), 1'b1, 2'd3,
                          make_flit(TYPE_HEAD, 64'h0000_0000_0000_0004), 1'b1, 2'b01);
            for (int k = 0; k < 20; k++) begin
                flit = make_flit(TYPE_DATA, {run_pattern(k + pkt), run_pattern(k + pkt + 1), 10'(k)});
                applyStimulus("p1_body", 1'b0, 5'b00010, rand_flit(), 1'b1, 2'(k), flit, 1'b1, 2'b01);
            end
            applyStimulus("p1_tail", 1'b0, 5'b00010, rand_flit(), 1'b1, 2'd0,
                          make_flit(TYPE_TAIL, 64'(pkt)), 1'b1, 2'b01);
            for (int g = 0; g < 7; g++) begin
                applyStimulus("p1_gap", 1'b0, 5'b00010, rand_flit(), 1'b1, 2'd2, '0, 1'b0, 2'b01);
            end
        end

        applyStimulus("p0_sel", 1'b0, 5'b00001, make_flit(TYPE_HEAD, 64'h9), 1'b1, 2'b10,
                      rand_flit(), 1'b1, 2'b01);

        applyStimulus("prio_both", 1'b0, 5'b00011, 66'h0_AAAA_0000_BBBB_0000, 1'b1, 2'd1,
                      66'h3_0000_CCCC_0000_DDDD, 1'b1, 2'd2);
        applyStimulus("upper_only", 1'b0, 5'b11100, 66'h0_AAAA_0000_BBBB_0000, 1'b1, 2'd1,
                      66'h3_0000_CCCC_0000_DDDD, 1'b1, 2'd2);
        applyStimulus("p1_upper", 1'b0, 5'b10010, 66'h0_AAAA_0000_BBBB_0000, 1'b1, 2'd1,
                      66'h3_0000_CCCC_0000_DDDD, 1'b1, 2'd2);

        flit_a = 66'h1_0A0A_0A0A_0A0A_0A0A;
        flit_b = 66'h2_0B0B_0B0B_0B0B_0B0B;
        applyStimulus("switch_a", 1'b0, SEL_P0, flit_a, 1'b1, 2'd1, flit_b, 1'b1, 2'd2);
        applyStimulus("switch_b", 1'b0, SEL_P1, flit_a, 1'b1, 2'd1, flit_b, 1'b1, 2'd2);

        applyStimulus("invalid_x", 1'b0, SEL_P1, 'x, 1'bx, 'x,
                      66'h1_2345_6789_ABCD_EF01, 1'b0, 2'd3);
        applyStimulus("p0_x1", 1'b0, SEL_P0, 66'h0_DEAD_BEEF_0000_0001, 1'b0, 2'd1,
                      'x, 1'bx, 'x);

        for (int i = 0; i < 300; i++) begin
            applyStimulus("random", ($urandom_range(0, 15) == 0), 5'($urandom),
                          rand_flit(), 1'($urandom), 2'($urandom),
                          rand_flit(), 1'($urandom), 2'($urandom));
        end
        applyStimulus("final_idle", 1'b0, 5'b00000, rand_flit(), 1'b1, 2'd1, rand_flit(), 1'b1, 2'd1);

        waited = 0;
        while (expected_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (expected_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expected_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
